// File: rtl/serializer_pkg.sv
// Shared defaults and word type for the parallel-in, serial-out word serializer.
package serializer_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 16;

  typedef logic signed [DATA_W-1:0] data_t;

endpackage : serializer_pkg

// File: rtl/serializer.sv
// Captures N signed words in one cycle, then emits one word per clock starting at element 0.
// Word 0 appears right after the load edge; there is no handshake, so the consumer samples every clock.
module serializer #(
  parameter int DATA_W = serializer_pkg::DATA_W,
  parameter int N      = serializer_pkg::N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] i_data [N-1:0],
  output logic signed [DATA_W-1:0] o_data
);

  logic signed [DATA_W-1:0] r_sreg  [N-1:0];
  logic signed [DATA_W-1:0] w_shift [N-1:0];

  // Shift toward slot 0; the top slot refills with zero so an exhausted stream reads 0.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_shift[k] = '0;
    end
    for (int k = 0; k < N - 1; k++) begin
      w_shift[k] = r_sreg[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int k = 0; k < N; k++) begin
        r_sreg[k] <= '0;
      end
    end else if (load_en) begin
      for (int k = 0; k < N; k++) begin
        r_sreg[k] <= i_data[k];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r_sreg[k] <= w_shift[k];
      end
    end
  end

  assign o_data = r_sreg[0];

endmodule : serializer

// File: tb/tb_serializer.sv
// Directed plus randomized bench for serializer, checked against a queue-based model of the word stream.
module tb_serializer;

  localparam int DATA_W = 32;
  localparam int N      = 16;

  logic                     clk;
  logic                     rst_n;
  logic                     load_en;
  logic                     clr;
  logic signed [DATA_W-1:0] i_data [N-1:0];
  logic signed [DATA_W-1:0] o_data;

  int checks   = 0;
  int failures = 0;

  // Words still waiting to be presented; front is what o_data must show.
  logic signed [DATA_W-1:0] model_q [$];

  serializer #(.DATA_W(DATA_W), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (load_en),
    .clr     (clr),
    .i_data  (i_data),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [DATA_W-1:0] model_out();
    if (model_q.size() > 0) return model_q[0];
    return '0;
  endfunction

  task automatic randomize_data();
    for (int k = 0; k < N; k++) i_data[k] = $signed($urandom());
  endtask

  // Apply the current inputs for one edge, advance the model, then check just after the edge.
  task automatic step(input string tag);
    logic signed [DATA_W-1:0] exp_v;
    @(posedge clk);
    if (!rst_n || clr) begin
      model_q.delete();
    end else if (load_en) begin
      model_q.delete();
      for (int k = 0; k < N; k++) model_q.push_back(i_data[k]);
    end else if (model_q.size() > 0) begin
      void'(model_q.pop_front());
    end
    #1;
    exp_v = model_out();
    checks++;
    assert (o_data === exp_v) else begin
      failures++;
      $error("FAIL %s: o_data=%0d expected=%0d", tag, o_data, exp_v);
    end
  endtask

  task automatic check_const(input string tag, input logic signed [DATA_W-1:0] exp_v);
    checks++;
    assert (o_data === exp_v) else begin
      failures++;
      $error("FAIL %s: o_data=%0d expected=%0d", tag, o_data, exp_v);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    load_en = 1'b1;
    clr     = 1'b0;
    randomize_data();

    // Reset dominates a simultaneous load.
    step("reset0");
    check_const("reset0_zero", 0);
    step("reset1");
    check_const("reset1_zero", 0);

    // Load 16..1 and drain fully, then hold at zero.
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) i_data[k] = DATA_W'(N - k);
    load_en = 1'b1;
    step("load_first");
    check_const("load_first_const", 16);
    load_en = 1'b0;
    for (int s = 1; s < N + 20; s++) begin
      randomize_data();
      step("drain");
      if (s == N - 1) check_const("drain_last_word", 1);
      if (s == N)     check_const("drain_exhausted", 0);
    end

    // Mid-stream reload with a negative constant.
    for (int k = 0; k < N; k++) i_data[k] = DATA_W'(N - k);
    load_en = 1'b1;
    step("reload_a");
    load_en = 1'b0;
    for (int s = 0; s < 5; s++) step("reload_shift");
    check_const("reload_before", 11);
    for (int k = 0; k < N; k++) i_data[k] = -32'sd7;
    load_en = 1'b1;
    step("reload_b");
    check_const("reload_neg", -32'sd7);
    load_en = 1'b0;
    for (int s = 0; s < N + 3; s++) begin
      randomize_data();
      step("reload_drain");
    end

    // clr beats load mid-drain.
    randomize_data();
    load_en = 1'b1;
    step("clr_load");
    load_en = 1'b0;
    for (int s = 0; s < 3; s++) step("clr_shift");
    clr = 1'b1;
    load_en = 1'b1;
    randomize_data();
    step("clr_vs_load");
    check_const("clr_vs_load_zero", 0);
    clr = 1'b0;
    load_en = 1'b0;
    for (int s = 0; s < 3; s++) step("clr_after");

    // Reset pulse mid-drain.
    randomize_data();
    load_en = 1'b1;
    step("rst_load");
    load_en = 1'b0;
    for (int s = 0; s < 3; s++) step("rst_shift");
    rst_n = 1'b0;
    step("rst_mid");
    check_const("rst_mid_zero", 0);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) step("rst_after");

    // Held load: output tracks i_data[0] one edge later.
    load_en = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      randomize_data();
      i_data[0] = DATA_W'(v * 100);
      step("hold_load");
      check_const("hold_load_const", DATA_W'(v * 100));
    end
    load_en = 1'b0;
    for (int s = 0; s < N + 1; s++) step("hold_drain");

    // Random traffic.
    for (int s = 0; s < 400; s++) begin
      randomize_data();
      load_en = ($urandom_range(0, 5) == 0);
      clr     = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 49) != 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serializer

// File: doc/serializer.md
Name: serializer

Overview:
Parallel-in, serial-out word serializer. Captures a vector of N signed words in one cycle, then presents one word per clock on o_data, starting from element 0. Sits between a block producing parallel results (e.g. a PE row or accumulator bank) and a single-word-wide stream consumer. There is no handshake; the consumer samples o_data on every clock.

Parameters:
DATA_W, 32, width of each signed word.
N, 16, number of words captured per load; N >= 2.

Ports:
clk  input  1  single clock, rising-edge active.
rst_n  input  1  synchronous, active-low reset.
load_en  input  1  high: capture i_data into the shift register this edge.
clr  input  1  synchronous clear of shift register contents, active-high.
i_data  input  signed [DATA_W-1:0] x N (unpacked [N-1:0])  parallel words to capture.
o_data  output  signed [DATA_W-1:0]  current serial word, equal to shift-register slot 0.

Behaviour:
- Reset/clock: one clock; reset synchronous, active-low; all logic on posedge clk.
- Storage: N registered slots, sreg[0..N-1], each DATA_W bits signed.
- o_data is driven directly from sreg[0]; there is no combinational path from inputs to o_data.
- Per-edge priority, highest first:
  1. rst_n==0: all slots <= 0.
  2. clr==1: all slots <= 0.
  3. load_en==1: sreg[k] <= i_data[k] for all k.
  4. otherwise (shift): sreg[k] <= sreg[k+1] for k < N-1; sreg[N-1] <= 0.
- Reset value: o_data = 0 and every slot = 0.
- Latency: at the edge where load_en is sampled high, o_data becomes i_data[0] immediately after that edge. Each following non-load, non-clr edge advances one word: i_data[1], i_data[2], ... up to i_data[N-1].
- Exhaustion: N edges after the last load, o_data = 0. It stays 0 until the next load; shifting zeros is harmless.
- Held load_en: while load_en stays high, the block reloads every cycle and o_data tracks i_data[0] with one cycle of delay.
- Mid-stream load: a new load overwrites all slots and restarts from element 0. Remaining unsent words are discarded.
- clr together with load_en: clr wins, slots go to 0.
- Reset mid-operation: all slots go to 0 at that edge, regardless of load_en/clr.
- Words pass through unmodified; there is no sign manipulation and no width change.

Decomposition:
- Package serializer_pkg: DATA_W and N defaults, and typedef data_t (logic signed [DATA_W-1:0]).
- Single flat module; no sub-module is needed. The slot array may be a generate loop over a per-slot register.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with load_en=1 and i_data arbitrary -> o_data=0 at every edge while in reset.
- Load and full drain:
  - Stimulus: i_data[15..0] = {1,2,...,16} (i_data[0]=16, i_data[15]=1); release rst_n; load_en=1 for one edge, then 0.
  - Response: o_data=16 after the load edge, then 15, 14, ..., 1 on successive edges, then 0 from edge 16 after the load onward, held for ~20 more edges.
- Mid-stream reload: after 5 shifts (o_data=11), load i_data all 32'sd-7 -> o_data=-7 on the next 16 edges, then 0. Signed value must be preserved.
- clr priority: mid-drain, assert clr=1 with load_en=1 -> o_data=0 next edge. With clr=0 and no load, o_data stays 0.
- Reset mid-drain: after a load and 3 shifts, pulse rst_n=0 for one edge -> o_data=0. Subsequent shifts stay 0 until a new load.
- Continuous load: hold load_en=1 while i_data[0] changes each cycle (100, 200, 300) -> o_data follows 100, 200, 300 with one-cycle latency.
